// File: rtl/icache_axi_pkg.sv
// Shared types and AXI constants for the icache line-refill engine.
// Imported by the refill block and its bench.
package icache_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_GNT,
    ST_HOLD
  } refill_state_e;

  localparam int DEF_LINE_WORDS = 8;
  localparam int OFFSET_BITS    = 5;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/icache_axi_refill.sv
// AXI4 read-side refill engine for the IF-stage icache.
// One INCR burst per line request, line returned with a one-cycle grant.
module icache_axi_refill
  import icache_axi_pkg::*;
#(
  parameter int         LINE_WORDS = DEF_LINE_WORDS,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        icache_rd_req,
  input  logic [31:0] icache_addr,
  output logic        icache_gnt,
  output logic [31:0] icache_data [LINE_WORDS],
  output logic        line_err,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] CNT_MAX = CW'(LINE_WORDS - 1);

  refill_state_e state, state_d;

  logic [CW-1:0] cnt;
  logic          err, err_d;
  logic          take_req;
  logic          beat;

  // Single outstanding burst, so rid and the line offset carry no information.
  logic unused_in;
  assign unused_in = ^{rid, icache_addr[OFFSET_BITS-1:0]};

  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

  assign take_req = (state == ST_IDLE) && icache_rd_req;
  assign beat     = (state == ST_R) && rvalid && rready;

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (icache_rd_req) state_d = ST_AR;
      ST_AR:   if (arvalid && arready) state_d = ST_R;
      ST_R:    if (beat && rlast) state_d = ST_GNT;
      ST_GNT:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err;
    if (take_req)
      err_d = 1'b0;
    else if (beat && (rresp != RESP_OKAY))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      icache_gnt <= 1'b0;
      line_err   <= 1'b0;
      araddr     <= '0;
      cnt        <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      arvalid    <= (state_d == ST_AR);
      rready     <= (state_d == ST_R);
      icache_gnt <= (state_d == ST_GNT);
      line_err   <= (state_d == ST_GNT) && err_d;
      err        <= err_d;
      if (take_req) begin
        araddr <= {icache_addr[31:OFFSET_BITS], OFFSET_BITS'(0)};
        cnt    <= '0;
      end else if (beat && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Overlong bursts keep overwriting the last word once cnt saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++)
        icache_data[i] <= '0;
    end else if (beat) begin
      icache_data[cnt] <= rdata;
    end
  end

endmodule
